// File: rtl/coklu_yazmac_obegi_pkg.sv
// rtl/coklu_yazmac_obegi_pkg.sv - shared defaults and port-slice helpers for the register file
// Contents:
//   VARS_*     default widths/counts used by coklu_yazmac_obegi and its bypass mux
//   dilim_alt  low bit index of slice `port` in a flattened bus of `genislik`-wide slices
package coklu_yazmac_obegi_pkg;

    localparam int VARS_VERI_BIT    = 32;
    localparam int VARS_N_YAZMAC    = 32;
    localparam int VARS_YAZMAC_BIT  = $clog2(VARS_N_YAZMAC);
    localparam int VARS_UOP_TAG_BIT = 6;

    function automatic int dilim_alt(input int port, input int genislik);
        return port * genislik;
    endfunction

endpackage

// File: rtl/yazmac_bypass_mux.sv
// rtl/yazmac_bypass_mux.sv - per-read-port writeback forwarding and priority select
// Built only when YAZMAC_BYPASS_EN is defined.
// Ports:
//   adres            read address of this port
//   kayitli_veri     registered data of the addressed register
//   kayitli_gecerli  registered valid bit of the addressed register
//   kayitli_etiket   registered producer tag of the addressed register
//   yaz_veri/yaz_adres/yaz_etiket/yaz_gecerli  flattened writeback ports
//   veri, gecerli    forwarded read data and valid
`ifdef YAZMAC_BYPASS_EN
module yazmac_bypass_mux
    import coklu_yazmac_obegi_pkg::*;
#(
    parameter int VERI_BIT    = VARS_VERI_BIT,
    parameter int YAZMAC_BIT  = VARS_YAZMAC_BIT,
    parameter int UOP_TAG_BIT = VARS_UOP_TAG_BIT,
    parameter int N_YAZ       = 2
) (
    input  logic [YAZMAC_BIT-1:0]        adres,
    input  logic [VERI_BIT-1:0]          kayitli_veri,
    input  logic                         kayitli_gecerli,
    input  logic [UOP_TAG_BIT-1:0]       kayitli_etiket,
    input  logic [N_YAZ*VERI_BIT-1:0]    yaz_veri,
    input  logic [N_YAZ*YAZMAC_BIT-1:0]  yaz_adres,
    input  logic [N_YAZ*UOP_TAG_BIT-1:0] yaz_etiket,
    input  logic [N_YAZ-1:0]             yaz_gecerli,
    output logic [VERI_BIT-1:0]          veri,
    output logic                         gecerli
);

    // Ascending scan so the highest matching port overrides lower ones.
    // A stale producer forwards its data but leaves validity as registered.
    always_comb begin
        veri    = kayitli_veri;
        gecerli = kayitli_gecerli;
        for (int j = 0; j < N_YAZ; j++) begin
            if (yaz_gecerli[j] && (adres != '0) &&
                (yaz_adres[dilim_alt(j, YAZMAC_BIT) +: YAZMAC_BIT] == adres)) begin
                veri    = yaz_veri[dilim_alt(j, VERI_BIT) +: VERI_BIT];
                gecerli = (yaz_etiket[dilim_alt(j, UOP_TAG_BIT) +: UOP_TAG_BIT] == kayitli_etiket)
                          ? 1'b1 : kayitli_gecerli;
            end
        end
    end

endmodule
`endif

// File: rtl/coklu_yazmac_obegi.sv
// rtl/coklu_yazmac_obegi.sv - multi-port register file with producer tags and validity scoreboard
// Optional feature macro: YAZMAC_BYPASS_EN (same-cycle writeback forwarding to read ports).
// Ports:
//   clk_i, rstn_i                    clock (rising edge), async active-low reset
//   oku_adres_i / oku_veri_o / oku_gecerli_o   N_OKU read ports (flattened slices)
//   yaz_veri_i / yaz_adres_i / yaz_etiket_i / yaz_gecerli_i  N_YAZ writeback ports
//   etiket_i / etiket_adres_i / etiket_gecerli_i  producer tag allocation
//   temizle_i                        flush: all registers valid, data kept
//   bekleyen_sayisi_o                registered count of not-valid registers
module coklu_yazmac_obegi
    import coklu_yazmac_obegi_pkg::*;
#(
    parameter int VERI_BIT    = VARS_VERI_BIT,
    parameter int N_YAZMAC    = VARS_N_YAZMAC,
    parameter int YAZMAC_BIT  = $clog2(N_YAZMAC),
    parameter int UOP_TAG_BIT = VARS_UOP_TAG_BIT,
    parameter int N_OKU       = 4,
    parameter int N_YAZ       = 2
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [N_OKU*YAZMAC_BIT-1:0]  oku_adres_i,
    output logic [N_OKU*VERI_BIT-1:0]    oku_veri_o,
    output logic [N_OKU-1:0]             oku_gecerli_o,
    input  logic [N_YAZ*VERI_BIT-1:0]    yaz_veri_i,
    input  logic [N_YAZ*YAZMAC_BIT-1:0]  yaz_adres_i,
    input  logic [N_YAZ*UOP_TAG_BIT-1:0] yaz_etiket_i,
    input  logic [N_YAZ-1:0]             yaz_gecerli_i,
    input  logic [UOP_TAG_BIT-1:0]       etiket_i,
    input  logic [YAZMAC_BIT-1:0]        etiket_adres_i,
    input  logic                         etiket_gecerli_i,
    input  logic                         temizle_i,
    output logic [$clog2(N_YAZMAC):0]    bekleyen_sayisi_o
);

    localparam int SAYAC_BIT = $clog2(N_YAZMAC) + 1;

    logic [VERI_BIT-1:0]    veri_q    [N_YAZMAC];
    logic [VERI_BIT-1:0]    veri_d    [N_YAZMAC];
    logic [UOP_TAG_BIT-1:0] etiket_q  [N_YAZMAC];
    logic [UOP_TAG_BIT-1:0] etiket_d  [N_YAZMAC];
    logic [N_YAZMAC-1:0]    gecerli_q;
    logic [N_YAZMAC-1:0]    gecerli_d;
    logic [SAYAC_BIT-1:0]   sayim_d;

    // Next state. Register 0 is skipped so it keeps its reset value forever.
    // Order of application sets priority: writebacks (ascending port index),
    // then allocation (overrides writeback validity), then flush.
    always_comb begin
        veri_d    = veri_q;
        etiket_d  = etiket_q;
        gecerli_d = gecerli_q;
        for (int r = 1; r < N_YAZMAC; r++) begin
            for (int j = 0; j < N_YAZ; j++) begin
                if (yaz_gecerli_i[j] &&
                    (yaz_adres_i[dilim_alt(j, YAZMAC_BIT) +: YAZMAC_BIT] == YAZMAC_BIT'(r))) begin
                    veri_d[r]    = yaz_veri_i[dilim_alt(j, VERI_BIT) +: VERI_BIT];
                    // Compared against the pre-edge tag; a mismatch is a stale producer.
                    gecerli_d[r] = (yaz_etiket_i[dilim_alt(j, UOP_TAG_BIT) +: UOP_TAG_BIT] == etiket_q[r])
                                   ? 1'b1 : gecerli_q[r];
                end
            end
            if (etiket_gecerli_i && !temizle_i && (etiket_adres_i == YAZMAC_BIT'(r))) begin
                etiket_d[r]  = etiket_i;
                gecerli_d[r] = 1'b0;
            end
        end
        if (temizle_i) begin
            gecerli_d = '1;
        end
    end

    always_comb begin
        sayim_d = '0;
        for (int r = 0; r < N_YAZMAC; r++) begin
            sayim_d = sayim_d + {{(SAYAC_BIT-1){1'b0}}, ~gecerli_d[r]};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            veri_q            <= '{default: '0};
            etiket_q          <= '{default: '0};
            gecerli_q         <= '1;
            bekleyen_sayisi_o <= '0;
        end else begin
            veri_q            <= veri_d;
            etiket_q          <= etiket_d;
            gecerli_q         <= gecerli_d;
            bekleyen_sayisi_o <= sayim_d;
        end
    end

    for (genvar k = 0; k < N_OKU; k++) begin : g_oku
        logic [YAZMAC_BIT-1:0] adres;
        assign adres = oku_adres_i[dilim_alt(k, YAZMAC_BIT) +: YAZMAC_BIT];
`ifdef YAZMAC_BYPASS_EN
        yazmac_bypass_mux #(
            .VERI_BIT    (VERI_BIT),
            .YAZMAC_BIT  (YAZMAC_BIT),
            .UOP_TAG_BIT (UOP_TAG_BIT),
            .N_YAZ       (N_YAZ)
        ) u_bypass (
            .adres           (adres),
            .kayitli_veri    (veri_q[adres]),
            .kayitli_gecerli (gecerli_q[adres]),
            .kayitli_etiket  (etiket_q[adres]),
            .yaz_veri        (yaz_veri_i),
            .yaz_adres       (yaz_adres_i),
            .yaz_etiket      (yaz_etiket_i),
            .yaz_gecerli     (yaz_gecerli_i),
            .veri            (oku_veri_o[dilim_alt(k, VERI_BIT) +: VERI_BIT]),
            .gecerli         (oku_gecerli_o[k])
        );
`else
        assign oku_veri_o[dilim_alt(k, VERI_BIT) +: VERI_BIT] = veri_q[adres];
        assign oku_gecerli_o[k] = gecerli_q[adres];
`endif
    end

endmodule

// File: tb/tb_coklu_yazmac_obegi.sv
// tb/tb_coklu_yazmac_obegi.sv - self-checking bench for coklu_yazmac_obegi
module tb_coklu_yazmac_obegi;

    localparam int VB = 32;
    localparam int NR = 32;
    localparam int AB = 5;
    localparam int TB = 6;
    localparam int NO = 4;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NO*AB-1:0] oku_adres;
    logic [NO*VB-1:0] oku_veri;
    logic [NO-1:0]    oku_gecerli;
    logic [NW*VB-1:0] yaz_veri;
    logic [NW*AB-1:0] yaz_adres;
    logic [NW*TB-1:0] yaz_etiket;
    logic [NW-1:0]    yaz_gecerli;
    logic [TB-1:0]    etiket;
    logic [AB-1:0]    etiket_adres;
    logic             etiket_gecerli;
    logic             temizle;
    logic [AB:0]      bekleyen;

    coklu_yazmac_obegi dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .oku_adres_i       (oku_adres),
        .oku_veri_o        (oku_veri),
        .oku_gecerli_o     (oku_gecerli),
        .yaz_veri_i        (yaz_veri),
        .yaz_adres_i       (yaz_adres),
        .yaz_etiket_i      (yaz_etiket),
        .yaz_gecerli_i     (yaz_gecerli),
        .etiket_i          (etiket),
        .etiket_adres_i    (etiket_adres),
        .etiket_gecerli_i  (etiket_gecerli),
        .temizle_i         (temizle),
        .bekleyen_sayisi_o (bekleyen)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [VB-1:0] m_veri    [NR];
    logic [TB-1:0] m_etiket  [NR];
    bit            m_gecerli [NR];
    int            m_say;

    typedef struct {
        bit a_en; int a_adr; int a_tag;
        bit w0_en; int w0_adr; int w0_tag; logic [31:0] w0_d;
        bit w1_en; int w1_adr; int w1_tag; logic [31:0] w1_d;
        bit fl; int rd; logic [31:0] e_d; bit e_v; int e_cnt;
    } vek_t;

    vek_t tablo [18];

    task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        n_chk++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
        end
    endtask

    function automatic void model_sifirla();
        for (int r = 0; r < NR; r++) begin
            m_veri[r] = '0; m_etiket[r] = '0; m_gecerli[r] = 1'b1;
        end
        m_say = 0;
    endfunction

    // Register-level rules: writebacks in port order (later port wins), a tag
    // match makes a register valid, a same-cycle allocation leaves it pending,
    // a flush makes everything valid and drops the allocation. x0 never changes.
    function automatic void model_adim();
        logic [VB-1:0] nv [NR];
        logic [TB-1:0] nt [NR];
        bit            ng [NR];
        int a;
        if (!rstn) return;
        nv = m_veri; nt = m_etiket; ng = m_gecerli;
        for (int j = 0; j < NW; j++) begin
            a = int'(yaz_adres[j*AB +: AB]);
            if (yaz_gecerli[j] && a != 0) begin
                nv[a] = yaz_veri[j*VB +: VB];
                ng[a] = (yaz_etiket[j*TB +: TB] == m_etiket[a]) ? 1'b1 : m_gecerli[a];
            end
        end
        a = int'(etiket_adres);
        if (etiket_gecerli && !temizle && a != 0) begin
            nt[a] = etiket; ng[a] = 1'b0;
        end
        if (temizle) foreach (ng[r]) ng[r] = 1'b1;
        m_veri = nv; m_etiket = nt; m_gecerli = ng;
        m_say = 0;
        foreach (ng[r]) if (!ng[r]) m_say++;
    endfunction

    function automatic void model_oku(input int a, output logic [VB-1:0] d, output bit v);
        d = m_veri[a];
        v = m_gecerli[a];
`ifdef YAZMAC_BYPASS_EN
        if (a != 0) begin
            for (int j = 0; j < NW; j++) begin
                if (yaz_gecerli[j] && int'(yaz_adres[j*AB +: AB]) == a) begin
                    d = yaz_veri[j*VB +: VB];
                    v = (yaz_etiket[j*TB +: TB] == m_etiket[a]) ? 1'b1 : m_gecerli[a];
                end
            end
        end
`endif
    endfunction

    task automatic girdi_temizle();
        yaz_veri = '0; yaz_adres = '0; yaz_etiket = '0; yaz_gecerli = '0;
        etiket = '0; etiket_adres = '0; etiket_gecerli = 1'b0; temizle = 1'b0;
    endtask

    task automatic adim();
        model_adim();
        @(posedge clk);
        #1;
    endtask

    task automatic oku_kontrol(input string ad);
        logic [VB-1:0] d;
        bit v;
        for (int k = 0; k < NO; k++) begin
            model_oku(int'(oku_adres[k*AB +: AB]), d, v);
            chk($sformatf("%s_veri_p%0d", ad, k), oku_veri[k*VB +: VB], d);
            chk($sformatf("%s_gecerli_p%0d", ad, k), oku_gecerli[k], v);
        end
    endtask

    task automatic satir_uygula(input vek_t t);
        girdi_temizle();
        etiket_gecerli = t.a_en; etiket_adres = AB'(t.a_adr); etiket = TB'(t.a_tag);
        yaz_gecerli[0] = t.w0_en; yaz_adres[0 +: AB] = AB'(t.w0_adr);
        yaz_etiket[0 +: TB] = TB'(t.w0_tag); yaz_veri[0 +: VB] = t.w0_d;
        yaz_gecerli[1] = t.w1_en; yaz_adres[AB +: AB] = AB'(t.w1_adr);
        yaz_etiket[TB +: TB] = TB'(t.w1_tag); yaz_veri[VB +: VB] = t.w1_d;
        temizle = t.fl;
    endtask

    initial begin
        //            a_en a_adr a_tag w0 adr tag data        w1 adr tag data    fl rd  e_d        e_v cnt
        tablo[0]  = '{1, 3,  5,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 3,  32'h0,      0, 1};
        tablo[1]  = '{0, 0,  0,  1, 3,  5,  32'hA5A5,   0, 0,  0,  32'h0, 0, 3,  32'hA5A5,   1, 0};
        tablo[2]  = '{1, 4,  7,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 4,  32'h0,      0, 1};
        tablo[3]  = '{0, 0,  0,  1, 4,  6,  32'h11,     0, 0,  0,  32'h0, 0, 4,  32'h11,     0, 1};
        tablo[4]  = '{0, 0,  0,  1, 9,  0,  32'h1,      1, 9,  0,  32'h2, 0, 9,  32'h2,      1, 1};
        tablo[5]  = '{1, 2,  1,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 2,  32'h0,      0, 2};
        tablo[6]  = '{1, 3,  2,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 3,  32'hA5A5,   0, 3};
        tablo[7]  = '{1, 5,  3,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 5,  32'h0,      0, 4};
        tablo[8]  = '{1, 6,  4,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 6,  32'h0,      0, 5};
        tablo[9]  = '{1, 7,  9,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 1, 7,  32'h0,      1, 0};
        tablo[10] = '{1, 10, 12, 0, 0,  0,  32'h0,      1, 10, 12, 32'h55, 0, 10, 32'h55,    0, 1};
        tablo[11] = '{0, 0,  0,  1, 10, 12, 32'h66,     0, 0,  0,  32'h0, 0, 10, 32'h66,     1, 0};
        tablo[12] = '{1, 0,  3,  1, 0,  0,  32'hFF,     0, 0,  0,  32'h0, 0, 0,  32'h0,      1, 0};
        tablo[13] = '{1, 11, 20, 0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 11, 32'h0,      0, 1};
        tablo[14] = '{0, 0,  0,  1, 11, 20, 32'h1,      1, 11, 21, 32'h2, 0, 11, 32'h2,      0, 1};
        tablo[15] = '{0, 0,  0,  1, 11, 21, 32'h3,      1, 11, 20, 32'h4, 0, 11, 32'h4,      1, 0};
        tablo[16] = '{1, 12, 1,  0, 0,  0,  32'h0,      0, 0,  0,  32'h0, 0, 12, 32'h0,      0, 1};
        tablo[17] = '{0, 0,  0,  1, 12, 9,  32'h99,     0, 0,  0,  32'h0, 1, 12, 32'h99,     1, 0};

        girdi_temizle();
        oku_adres = '0;
        model_sifirla();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state across every address on every port.
        for (int b = 0; b < NR; b += NO) begin
            for (int k = 0; k < NO; k++) oku_adres[k*AB +: AB] = AB'(b + k);
            #1;
            for (int k = 0; k < NO; k++) begin
                chk($sformatf("reset_veri_x%0d", b + k), oku_veri[k*VB +: VB], 0);
                chk($sformatf("reset_gecerli_x%0d", b + k), oku_gecerli[k], 1);
            end
        end
        chk("reset_sayac", bekleyen, 0);

        // Directed table: one cycle of inputs, then read back with idle inputs.
        for (int i = 0; i < 18; i++) begin
            satir_uygula(tablo[i]);
            adim();
            girdi_temizle();
            for (int k = 0; k < NO; k++) oku_adres[k*AB +: AB] = AB'(tablo[i].rd);
            #1;
            chk($sformatf("tablo%0d_veri", i), oku_veri[0 +: VB], tablo[i].e_d);
            chk($sformatf("tablo%0d_gecerli", i), oku_gecerli[0], tablo[i].e_v);
            chk($sformatf("tablo%0d_veri_p3", i), oku_veri[3*VB +: VB], tablo[i].e_d);
            chk($sformatf("tablo%0d_sayac", i), bekleyen, tablo[i].e_cnt);
        end

        // Same-cycle read of a register under writeback.
        satir_uygula('{1, 8, 13, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0});
        adim();
        satir_uygula('{0, 0, 0, 1, 8, 13, 32'hDEAD, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0});
        oku_adres = '0;
        oku_adres[3*AB +: AB] = AB'(8);
        #1;
`ifdef YAZMAC_BYPASS_EN
        chk("bypass_x8_veri", oku_veri[3*VB +: VB], 32'hDEAD);
        chk("bypass_x8_gecerli", oku_gecerli[3], 1);
`else
        chk("nobypass_x8_veri", oku_veri[3*VB +: VB], 0);
        chk("nobypass_x8_gecerli", oku_gecerli[3], 0);
`endif
        yaz_adres[0 +: AB] = '0;
        oku_adres[3*AB +: AB] = '0;
        #1;
        chk("bypass_x0_veri", oku_veri[3*VB +: VB], 0);
        chk("bypass_x0_gecerli", oku_gecerli[3], 1);
        adim();
        girdi_temizle();

        // Randomised traffic with heavy address and tag collisions.
        for (int i = 0; i < 400; i++) begin
            yaz_gecerli = NW'($urandom_range(0, 3));
            for (int j = 0; j < NW; j++) begin
                yaz_adres[j*AB +: AB]  = AB'($urandom_range(0, 7));
                yaz_etiket[j*TB +: TB] = TB'($urandom_range(0, 3));
                yaz_veri[j*VB +: VB]   = VB'($urandom);
            end
            etiket_gecerli = ($urandom_range(0, 2) != 0);
            etiket_adres   = AB'($urandom_range(0, 7));
            etiket         = TB'($urandom_range(0, 3));
            temizle        = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NO; k++) oku_adres[k*AB +: AB] = AB'($urandom_range(0, 7));
            #1;
            oku_kontrol($sformatf("rnd%0d", i));
            adim();
            chk($sformatf("rnd%0d_sayac", i), bekleyen, m_say);
        end
        girdi_temizle();

        // Asynchronous reset mid-cycle, with an allocation held during reset.
        satir_uygula('{1, 5, 1, 0, 0, 0, 32'h0, 1, 6, 3, 32'h1234, 0, 0, 32'h0, 0, 0});
        adim();
        satir_uygula('{1, 6, 2, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0});
        oku_adres = '0;
        oku_adres[0 +: AB] = AB'(5);
        oku_adres[AB +: AB] = AB'(6);
        #2;
        rstn = 1'b0;
        model_sifirla();
        #1;
        chk("async_reset_x5_gecerli", oku_gecerli[0], 1);
        chk("async_reset_x6_veri", oku_veri[VB +: VB], 0);
        chk("async_reset_sayac", bekleyen, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        girdi_temizle();
        #1;
        chk("reset_hold_x6_gecerli", oku_gecerli[1], 1);
        chk("reset_hold_sayac", bekleyen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coklu_yazmac_obegi.md
# coklu_yazmac_obegi

Parametrised multi-port register file with per-register producer tags and a validity scoreboard. It is the successor of the single-write, dual-read register file: read, write and tag-allocation port counts are configurable, and it adds priority rules, a flush, a pending-register counter and optional same-cycle bypass. It sits between rename/dispatch, which allocates tags and reads operands, and the writeback ports of the execution units.

## Interface
- `VERI_BIT`, 32: register data width.
- `N_YAZMAC`, 32: register count; register 0 is hardwired to zero and always valid.
- `YAZMAC_BIT`, $clog2(N_YAZMAC): register address width.
- `UOP_TAG_BIT`, 6: producer tag width.
- `N_OKU`, 4: number of read ports.
- `N_YAZ`, 2: number of writeback ports.
- `clk_i`  in  1  clock, rising edge.
- `rstn_i`  in  1  reset: asynchronous assert, active-low, release synchronised externally.
- `oku_adres_i`  in  N_OKU*YAZMAC_BIT  read addresses; port k occupies slice k.
- `oku_veri_o`  out  N_OKU*VERI_BIT  read data per port.
- `oku_gecerli_o`  out  N_OKU  read data valid (no outstanding producer).
- `yaz_veri_i`  in  N_YAZ*VERI_BIT  writeback data.
- `yaz_adres_i`  in  N_YAZ*YAZMAC_BIT  writeback destination.
- `yaz_etiket_i`  in  N_YAZ*UOP_TAG_BIT  tag of the producing uop.
- `yaz_gecerli_i`  in  N_YAZ  writeback strobe per port.
- `etiket_i`  in  UOP_TAG_BIT  newly allocated producer tag.
- `etiket_adres_i`  in  YAZMAC_BIT  destination that receives the new tag.
- `etiket_gecerli_i`  in  1  tag allocation strobe.
- `temizle_i`  in  1  flush: marks all registers valid and keeps data.
- `bekleyen_sayisi_o`  out  $clog2(N_YAZMAC)+1  registered count of registers that are not valid.

## Operation
- Per-register state: data, tag and valid bit.
- Reset state: data 0, tag 0, valid 1, `bekleyen_sayisi_o` = 0.
- Reads are combinational from state. After reset, every `oku_veri_o` slice is 0 and every `oku_gecerli_o` bit is 1.
- Tag allocation with `etiket_gecerli_i`: at the next edge, tag[a] = `etiket_i` and valid[a] = 0.
- Writeback on port j: data[a] = `yaz_veri_i`. valid[a] = 1 only if `yaz_etiket_i` equals the stored tag, compared against the pre-edge tag. Otherwise valid is unchanged (stale producer). Data is always written.
- Two writeback ports hitting the same register in one cycle: the highest port index wins data and the valid decision.
- Allocation and writeback to the same register in one cycle: data comes from the writeback, the tag is the new tag, and valid = 0 (the newer producer is outstanding).
- `temizle_i` has the highest priority. Every valid bit is set to 1 and the allocation in the same cycle is discarded. Writeback data in the same cycle is still written.
- Address 0: writes and allocations are ignored, so the register always reads 0 and valid 1.
- `bekleyen_sayisi_o` equals the popcount of ~valid over the next state, registered. It is 0 after a flush and never exceeds N_YAZMAC-1.

## Timing
- Read latency is 0 cycles from registered state. With bypass enabled, the path also runs combinationally from the write inputs.
- Write, allocation and flush take effect at the next rising edge of `clk_i`.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock. Inputs are ignored while `rstn_i` = 0.
- `bekleyen_sayisi_o` is updated at the same edge as the valid bits it counts.

## Configuration
- `YAZMAC_BYPASS_EN` defined:
  - A read whose address matches a valid writeback in the same cycle returns `yaz_veri_i`, using the highest matching port index.
  - `oku_gecerli_o` = 1 for that read if the tag matches the stored tag.
  - Address 0 is never bypassed.
- Not defined: reads see only state registered at the previous edge.

## Structure
- Shared package: `VERI_BIT`, `YAZMAC_BIT`, `UOP_TAG_BIT` and `N_YAZMAC` defaults, plus the port-slice index helpers.
- Sub-module `yazmac_bypass_mux`: one instance per read port. It performs the writeback address match and priority select, and is instantiated only under `YAZMAC_BYPASS_EN`.

## Test plan
- Reset, then read all addresses -> data 0 and valid 1 on all ports; `bekleyen_sayisi_o` = 0.
- Allocate tag 5 to x3, then write x3 with tag 5 and data 0xA5A5 one cycle later -> valid 0 after the first edge and 1 after the second; data reads 0xA5A5; count goes 1 -> 0.
- Allocate tag 7 to x4, then write x4 with tag 6 and data 0x11 -> data 0x11, valid stays 0, count = 1.
- Ports 0 and 1 write x9 with data 0x1 and 0x2 in the same cycle, both tags matching -> x9 reads 0x2 and valid 1.
- Allocate x2..x6, then assert `temizle_i` together with an allocation to x7 -> all valid 1, x7 tag unchanged, count = 0.
- With `YAZMAC_BYPASS_EN`, write x8 = 0xDEAD with a matching tag while reading x8 on port 3 in the same cycle -> port 3 returns 0xDEAD with valid 1 in that cycle. The same stimulus to x0 returns 0.
